// File: rtl/button_debounce_multi_if.sv
// Button conditioner interface: raw buttons in, debounced level and
// one-cycle event pulses out. The debouncer sits on the slave side.
interface button_debounce_multi_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] button;         // raw asynchronous buttons, 1 = pressed
  logic [N_BTN-1:0] level;          // debounced level
  logic [N_BTN-1:0] press_pulse;    // one cycle on accepted 0->1
  logic [N_BTN-1:0] release_pulse;  // one cycle on accepted 1->0
  logic [N_BTN-1:0] long_pulse;     // one cycle once the hold reaches LONG_CNT ticks

  // Board side: drives buttons and consumes the conditioned outputs.
  modport master (
    output button,
    input  level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  // Debouncer side.
  modport slave (
    input  button,
    output level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel pushbutton conditioner.
// Each raw button passes through a two-flop synchroniser. It is then
// debounced by a per-channel stability counter that advances only on a
// shared prescaler tick. A new level is accepted after STABLE_CNT
// consecutive ticks that disagree with the current level. All outputs are
// registered, so there is no combinational path from button to any output.
module button_debounce_multi #(
  parameter int N_BTN      = 5,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 4,
  parameter int LONG_CNT   = 200
) (
  input  logic                   clk_in,
  input  logic                   reset,
  button_debounce_multi_if.slave bus
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int STAB_W = $clog2(STABLE_CNT + 1);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);

  // Synchroniser: sync2_q is the raw button delayed by two clocks.
  logic [N_BTN-1:0]  sync1_q;
  logic [N_BTN-1:0]  sync2_q;

  // Shared sample-tick prescaler.
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic              tick;

  // Per-channel debounce and hold state.
  logic [STAB_W-1:0] stab_q [N_BTN];
  logic [STAB_W-1:0] stab_d [N_BTN];
  logic [HOLD_W-1:0] hold_q [N_BTN];
  logic [HOLD_W-1:0] hold_d [N_BTN];

  // Registered outputs.
  logic [N_BTN-1:0]  level_q;
  logic [N_BTN-1:0]  level_d;
  logic [N_BTN-1:0]  press_q;
  logic [N_BTN-1:0]  press_d;
  logic [N_BTN-1:0]  rel_q;
  logic [N_BTN-1:0]  rel_d;
  logic [N_BTN-1:0]  long_q;
  logic [N_BTN-1:0]  long_d;

  // Prescaler: counts 0..TICK_DIV-1 and wraps; tick marks the last count.
  always_comb begin
    tick  = (div_q == DIV_W'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // Per-channel next state: stability filter, level update, pulses, hold counter.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that
    // leaves a combinational output unassigned would infer a latch.
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      stab_d[i] = stab_q[i];
      hold_d[i] = hold_q[i];
    end

    for (int i = 0; i < N_BTN; i++) begin
      // Stability filter: only disagreeing samples on ticks count, and any
      // agreeing sample restarts the count, so short bounces are dropped.
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          stab_d[i] = '0;
        end else if (int'(stab_q[i]) + 1 < STABLE_CNT) begin
          stab_d[i] = stab_q[i] + STAB_W'(1);
        end else begin
          level_d[i] = sync2_q[i];
          stab_d[i]  = '0;
          press_d[i] = sync2_q[i];
          rel_d[i]   = ~sync2_q[i];
        end
      end

      // Hold counter: counts ticks of accepted-high level and saturates.
      // The long pulse fires on the single tick that reaches LONG_CNT, so
      // it cannot repeat until the level has dropped and the count cleared.
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && (int'(hold_q[i]) < LONG_CNT)) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        if (int'(hold_q[i]) + 1 == LONG_CNT) begin
          long_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      // NOTE: these arrays are per-channel control state, not data storage,
      // so they are reset like any other counter.
      for (int i = 0; i < N_BTN; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q <= bus.button;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      for (int i = 0; i < N_BTN; i++) begin
        stab_q[i] <= stab_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bus.level         = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.long_pulse    = long_q;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi with N_BTN=2, TICK_DIV=4, STABLE_CNT=3,
// LONG_CNT=5. A table of phases (inputs, duration, expected final level and
// expected pulse counts) is pushed to a scoreboard queue as each phase is
// driven and popped when the phase's outputs have been collected. Short
// hand-written sequences then pin down exact latencies and corner cases.
module tb_button_debounce_multi;

  localparam int N_BTN      = 2;
  localparam int TICK_DIV   = 4;
  localparam int STABLE_CNT = 3;
  localparam int LONG_CNT   = 5;

  logic clk_in = 1'b0;
  logic reset;

  button_debounce_multi_if #(.N_BTN(N_BTN)) bus ();

  button_debounce_multi #(
    .N_BTN      (N_BTN),
    .TICK_DIV   (TICK_DIV),
    .STABLE_CNT (STABLE_CNT),
    .LONG_CNT   (LONG_CNT)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] btn;
    int         cycles;
    logic [1:0] exp_level;
    int         p0, p1, r0, r1, l0, l1;   // expected pulse counts per channel
  } vec_t;

  vec_t tbl [9];
  vec_t sb_q [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic rst, input logic [1:0] btn,
                              input int cycles, input logic [1:0] lvl,
                              input int p0, input int p1, input int r0,
                              input int r1, input int l0, input int l1);
    vec_t v;
    v.name = name; v.rst = rst; v.btn = btn; v.cycles = cycles; v.exp_level = lvl;
    v.p0 = p0; v.p1 = p1; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
    return v;
  endfunction

  initial begin
    int   pc [2];
    int   rc [2];
    int   lc [2];
    int   n;
    bit   found;
    vec_t e;

    reset      = 1'b1;
    bus.button = 2'b00;

    //                name        rst  btn    cyc  lvl    p0 p1 r0 r1 l0 l1
    tbl[0] = mk("reset",      1'b1, 2'b00,   3, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk("idle",       1'b0, 2'b00,  40, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk("press0",     1'b0, 2'b01,  24, 2'b01, 1, 0, 0, 0, 0, 0);
    tbl[3] = mk("bounce1",    1'b0, 2'b11,   6, 2'b01, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk("hold0",      1'b0, 2'b01, 100, 2'b01, 0, 0, 0, 0, 1, 0);
    tbl[5] = mk("release0",   1'b0, 2'b00,  24, 2'b00, 0, 0, 1, 0, 0, 0);
    tbl[6] = mk("press11",    1'b0, 2'b11,  24, 2'b11, 1, 1, 0, 0, 0, 0);
    tbl[7] = mk("rst_mid",    1'b1, 2'b11,   1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[8] = mk("repress11",  1'b0, 2'b11,  24, 2'b11, 1, 1, 0, 0, 0, 0);

    for (int k = 0; k < 9; k++) begin
      reset      = tbl[k].rst;
      bus.button = tbl[k].btn;
      sb_q.push_back(tbl[k]);
      for (int c = 0; c < 2; c++) begin
        pc[c] = 0; rc[c] = 0; lc[c] = 0;
      end
      repeat (tbl[k].cycles) begin
        cycle();
        for (int c = 0; c < 2; c++) begin
          pc[c] += int'(bus.press_pulse[c]   === 1'b1);
          rc[c] += int'(bus.release_pulse[c] === 1'b1);
          lc[c] += int'(bus.long_pulse[c]    === 1'b1);
        end
      end
      e = sb_q.pop_front();
      check({e.name, " level"}, int'(bus.level), int'(e.exp_level));
      check({e.name, " press0"},   pc[0], e.p0);
      check({e.name, " press1"},   pc[1], e.p1);
      check({e.name, " release0"}, rc[0], e.r0);
      check({e.name, " release1"}, rc[1], e.r1);
      check({e.name, " long0"},    lc[0], e.l0);
      check({e.name, " long1"},    lc[1], e.l1);
    end

    // Exact press latency and single-cycle pulse width on channel 0.
    reset      = 1'b0;
    bus.button = 2'b00;
    repeat (30) cycle();
    check("h1 level before", int'(bus.level), 0);
    bus.button = 2'b01;
    n = 0; found = 0;
    while (!found && n < 40) begin
      cycle(); n++;
      if (bus.press_pulse != 2'b00) found = 1;
    end
    check("h1 press seen", int'(found), 1);
    check("h1 press latency<=18", int'(n <= 18), 1);
    check("h1 press vector", int'(bus.press_pulse), 1);
    check("h1 level at press", int'(bus.level), 1);
    cycle();
    check("h1 press width", int'(bus.press_pulse), 0);

    // Long pulse exactly 20 cycles after the press pulse, then never again.
    n = 1; found = 0;
    while (!found && n < 60) begin
      if (bus.long_pulse[0]) found = 1;
      else begin
        cycle(); n++;
      end
    end
    check("h1 long seen", int'(found), 1);
    check("h1 long delay", n, 20);
    n = 0;
    repeat (100) begin
      cycle();
      n += int'(bus.long_pulse != 2'b00);
    end
    check("h1 no repeat long", n, 0);

    // Release of channel 0.
    bus.button = 2'b00;
    n = 0; found = 0;
    while (!found && n < 40) begin
      cycle(); n++;
      if (bus.release_pulse != 2'b00) found = 1;
    end
    check("h1 release seen", int'(found), 1);
    check("h1 release vector", int'(bus.release_pulse), 1);
    check("h1 level at release", int'(bus.level), 0);

    // Simultaneous press on both channels lands in one cycle.
    repeat (10) cycle();
    bus.button = 2'b11;
    n = 0; found = 0;
    while (!found && n < 40) begin
      cycle(); n++;
      if (bus.press_pulse != 2'b00) found = 1;
    end
    check("h2 press seen", int'(found), 1);
    check("h2 press vector", int'(bus.press_pulse), 3);
    check("h2 level at press", int'(bus.level), 3);

    // One-cycle reset while held: level drops silently, press returns after 3 ticks.
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("h3 level after reset", int'(bus.level), 0);
    check("h3 release after reset", int'(bus.release_pulse), 0);
    n = 0; found = 0; rc[0] = 0;
    while (!found && n < 40) begin
      cycle(); n++;
      rc[0] += int'(bus.release_pulse != 2'b00);
      if (bus.press_pulse[0]) found = 1;
    end
    check("h3 repress seen", int'(found), 1);
    check("h3 repress delay", n, 12);
    check("h3 no release", rc[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
